// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
// Shared types for the MEM pipeline stage:
//   u1/u8/u64            basic scalar typedefs
//   XLEN/ADDR_W/STRB_W   datapath, bus address and byte-strobe widths
//   msize_t, MSIZE*      bus access size encoding (1/2/4/8 bytes = 0/1/2/3)
//   mem_op_t             load/store operation selector carried in the control word
//   control_t            decode control bits travelling down the pipe
//   execute_data_t       EX/MEM register payload consumed by memory_access
//   memory_data_t        MEM/WB payload produced by memory_access
//   mem_state_t          MEM stage FSM states
// Optional build macro MEM_MISALIGN_TRAP_EN adds the misalign flag to
// memory_data_t and the alignment-mask helper.
// -----------------------------------------------------------------------------
package memory_access_pkg;

    typedef logic        u1;
    typedef logic [7:0]  u8;
    typedef logic [63:0] u64;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;
    localparam int STRB_W = XLEN / 8;

    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    typedef enum logic [3:0] {
        MEM_NONE,
        MEM_LB, MEM_LH, MEM_LW, MEM_LD,
        MEM_LBU, MEM_LHU, MEM_LWU,
        MEM_SB, MEM_SH, MEM_SW, MEM_SD
    } mem_op_t;

    typedef struct packed {
        u1       regwrite;
        u1       memread;
        u1       memwrite;
        u1       nop_signal;
        mem_op_t mem_op;
    } control_t;

    typedef struct packed {
        u64         pc;
        u64         result_alu;
        u64         wd;
        logic [4:0] wa;
        control_t   ctl;
    } execute_data_t;

    typedef struct packed {
        u64         pc;
        logic [4:0] wa;
        u64         wd;
        control_t   ctl;
        u1          valid;
`ifdef MEM_MISALIGN_TRAP_EN
        u1          misalign;
`endif
    } memory_data_t;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} mem_state_t;

    function automatic msize_t msize_of(input mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: msize_of = MSIZE1;
            MEM_LH, MEM_LHU, MEM_SH: msize_of = MSIZE2;
            MEM_LW, MEM_LWU, MEM_SW: msize_of = MSIZE4;
            default:                 msize_of = MSIZE8;
        endcase
    endfunction

    // Byte-lane mask of an access placed at lane 0.
    function automatic u8 size_mask(input msize_t size);
        case (size)
            MSIZE1:  size_mask = 8'h01;
            MSIZE2:  size_mask = 8'h03;
            MSIZE4:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input msize_t size);
        case (size)
            MSIZE1:  align_mask = 3'b000;
            MSIZE2:  align_mask = 3'b001;
            MSIZE4:  align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction
`endif

endpackage

// File: rtl/memory_access_if.sv
// -----------------------------------------------------------------------------
// memory_access_if
// Data bus between the MEM stage (master) and memory (slave).
//   dreq_valid   request valid
//   dreq_addr    byte address
//   dreq_size    access size (MSIZE*)
//   dreq_strobe  byte-lane write enables, zero for loads
//   dreq_data    store data already shifted into its lanes
//   dresp_ok     response / completion
//   dresp_data   read data, lane-aligned
// -----------------------------------------------------------------------------
interface memory_access_if;
    import memory_access_pkg::*;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    msize_t            dreq_size;
    logic [STRB_W-1:0] dreq_strobe;
    logic [XLEN-1:0]   dreq_data;
    logic              dresp_ok;
    logic [XLEN-1:0]   dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_ok, dresp_data
    );

endinterface

// File: rtl/memory_access_mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational byte-lane alignment for the MEM stage.
//   op         load/store operation
//   addr_lo    address bits [2:0] (byte offset inside the 8-byte line)
//   store_in   register store data (lane 0 aligned)
//   load_in    bus read data (lane aligned)
//   strobe     byte enables for stores, zero otherwise
//   store_out  store data shifted into its lanes
//   load_out   read data shifted down and sign/zero extended
// Lanes past byte 7 are simply truncated by the shifts.
// -----------------------------------------------------------------------------
module mem_align
    import memory_access_pkg::*;
(
    input  mem_op_t           op,
    input  logic [2:0]        addr_lo,
    input  u64                store_in,
    input  u64                load_in,
    output logic [STRB_W-1:0] strobe,
    output u64                store_out,
    output u64                load_out
);

    logic [5:0] shamt;
    logic       is_store;
    u8          lane_mask;
    u64         raw;

    assign shamt     = {addr_lo, 3'b000};
    assign is_store  = op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SD};
    assign lane_mask = size_mask(msize_of(op));
    assign raw       = load_in >> shamt;

    assign strobe    = is_store ? (lane_mask << addr_lo) : '0;
    assign store_out = store_in << shamt;

    always_comb begin
        load_out = raw;
        case (op)
            MEM_LB:  load_out = {{56{raw[7]}},  raw[7:0]};
            MEM_LH:  load_out = {{48{raw[15]}}, raw[15:0]};
            MEM_LW:  load_out = {{32{raw[31]}}, raw[31:0]};
            MEM_LBU: load_out = {56'b0, raw[7:0]};
            MEM_LHU: load_out = {48'b0, raw[15:0]};
            MEM_LWU: load_out = {32'b0, raw[31:0]};
            default: load_out = raw;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// MEM pipeline stage. Takes the EX/MEM payload, runs loads/stores on the data
// bus and produces the writeback payload plus stallM for earlier stages.
//   clk     clock
//   reset   synchronous, active-high
//   dataE   EX/MEM payload (result_alu is the address, wd the store data)
//   stallW  MEM/WB cannot accept this cycle
//   dbus    data bus, master side
//   dataM   writeback payload; valid only when presented with stallM=0
//   stallM  MEM busy, EX/MEM and earlier must hold
// Build macro MEM_MISALIGN_TRAP_EN: misaligned accesses issue no request and
// are flagged through dataM.misalign; without it low address bits are used
// unchecked.
// Request fields are driven straight from dataE: while stallM is high the
// EX/MEM register holds, so the request stays constant through WAIT.
// -----------------------------------------------------------------------------
module memory_access
    import memory_access_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  execute_data_t  dataE,
    input  logic           stallW,
    memory_access_if.master dbus,
    output memory_data_t   dataM,
    output logic           stallM
);

    mem_state_t state_reg, state_next;
    u64         hold_wd_reg, hold_wd_next;

    logic       is_mem;
    logic       misalign;
    logic       do_req;
    u64         load_res;
    u64         mem_wd;

    assign is_mem = (dataE.ctl.memread | dataE.ctl.memwrite) & ~dataE.ctl.nop_signal;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = is_mem &&
        ((dataE.result_alu[2:0] & align_mask(msize_of(dataE.ctl.mem_op))) != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    assign do_req = is_mem & ~misalign;

    mem_align u_align (
        .op        (dataE.ctl.mem_op),
        .addr_lo   (dataE.result_alu[2:0]),
        .store_in  (dataE.wd),
        .load_in   (dbus.dresp_data),
        .strobe    (dbus.dreq_strobe),
        .store_out (dbus.dreq_data),
        .load_out  (load_res)
    );

    assign dbus.dreq_addr = dataE.result_alu[ADDR_W-1:0];
    assign dbus.dreq_size = msize_of(dataE.ctl.mem_op);

    // Stores have no writeback value; forward the address to keep wd defined.
    assign mem_wd = dataE.ctl.memread ? load_res : dataE.result_alu;

    always_comb begin
        state_next      = state_reg;
        hold_wd_next    = hold_wd_reg;
        dbus.dreq_valid = 1'b0;
        stallM          = 1'b0;
        dataM           = '0;
        dataM.pc        = dataE.pc;
        dataM.wa        = dataE.wa;
        dataM.ctl       = dataE.ctl;
        dataM.wd        = dataE.result_alu;

        case (state_reg)
            IDLE: begin
                if (do_req) begin
                    dbus.dreq_valid = 1'b1;
                    if (dbus.dresp_ok) begin
                        dataM.wd = mem_wd;
                        stallM   = stallW;
                        if (stallW) begin
                            hold_wd_next = mem_wd;
                            state_next   = HOLD;
                        end else begin
                            dataM.valid = 1'b1;
                        end
                    end else begin
                        stallM     = 1'b1;
                        state_next = WAIT;
                    end
                end else begin
                    stallM      = stallW;
                    dataM.valid = ~stallW & ~dataE.ctl.nop_signal;
                    if (misalign) begin
                        dataM.ctl.regwrite = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        dataM.misalign     = 1'b1;
`endif
                    end
                end
            end
            WAIT: begin
                dbus.dreq_valid = 1'b1;
                if (dbus.dresp_ok) begin
                    dataM.wd = mem_wd;
                    stallM   = stallW;
                    if (stallW) begin
                        hold_wd_next = mem_wd;
                        state_next   = HOLD;
                    end else begin
                        dataM.valid = 1'b1;
                        state_next  = IDLE;
                    end
                end else begin
                    stallM = 1'b1;
                end
            end
            HOLD: begin
                // Bus access already done; only wait for writeback to accept.
                dataM.wd = hold_wd_reg;
                stallM   = stallW;
                if (!stallW) begin
                    dataM.valid = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Reset silences the bus and the pipeline in the same cycle.
        if (reset) begin
            dbus.dreq_valid = 1'b0;
            stallM          = 1'b0;
            dataM.valid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            hold_wd_reg <= '0;
        end else begin
            state_reg   <= state_next;
            hold_wd_reg <= hold_wd_next;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
// Self-checking bench for memory_access. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge. Expected writeback
// payloads are queued when an instruction is presented and popped when the
// stage reports dataM.valid.
// -----------------------------------------------------------------------------
module tb_memory_access;
    import memory_access_pkg::*;

    typedef struct {
        u64 pc;
        u64 wd;
        bit wd_chk;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          stallW;
    memory_data_t  dataM;
    logic          stallM;

    memory_access_if dbus();

    memory_access dut (
        .clk    (clk),
        .reset  (reset),
        .dataE  (dataE),
        .stallW (stallW),
        .dbus   (dbus),
        .dataM  (dataM),
        .stallM (stallM)
    );

    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    sb_t exp_q[$];

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input u64 pc, input mem_op_t op, input u64 addr, input u64 wd);
        dataE                = '0;
        dataE.pc             = pc;
        dataE.result_alu     = addr;
        dataE.wd             = wd;
        dataE.wa             = 5'd10;
        dataE.ctl.mem_op     = op;
        dataE.ctl.memread    = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU};
        dataE.ctl.memwrite   = op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SD};
        dataE.ctl.regwrite   = ~dataE.ctl.memwrite;
    endtask

    task automatic set_bubble;
        dataE                = '0;
        dataE.ctl.nop_signal = 1'b1;
    endtask

    task automatic test_reset;
        reset           = 1'b1;
        stallW          = 1'b0;
        dbus.dresp_ok   = 1'b0;
        dbus.dresp_data = '0;
        set_op(64'h10, MEM_LD, 64'h8000_0000, 64'h0);
        repeat (2) next_cycle;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_dreq_valid: got %b want 0", dbus.dreq_valid);
        end
        n_vec++;
        if (stallM !== 1'b0) begin
            n_err++; $display("FAIL reset_stallM: got %b want 0", stallM);
        end
        n_vec++;
        if (dataM.valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", dataM.valid);
        end
        next_cycle;
        reset = 1'b0;
        set_bubble();
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0 || dataM.valid !== 1'b0 || stallM !== 1'b0) begin
            n_err++; $display("FAIL post_reset_bubble: dreq_valid=%b valid=%b stallM=%b want 0/0/0",
                              dbus.dreq_valid, dataM.valid, stallM);
        end
        next_cycle;
    endtask

    task automatic test_store_wait;
        sb_t e;
        set_op(64'h100, MEM_SD, 64'h8000_0008, 64'h1122_3344_5566_7788);
        exp_q.push_back('{pc: 64'h100, wd: 64'h0, wd_chk: 1'b0});
        dbus.dresp_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (dbus.dreq_valid !== 1'b1 || dbus.dreq_addr !== 64'h8000_0008) begin
                n_err++; $display("FAIL sd_req_c%0d: valid=%b addr=%h want 1/0000000080000008",
                                  i, dbus.dreq_valid, dbus.dreq_addr);
            end
            n_vec++;
            if (dbus.dreq_strobe !== 8'hFF || dbus.dreq_size !== MSIZE8 ||
                dbus.dreq_data !== 64'h1122_3344_5566_7788) begin
                n_err++; $display("FAIL sd_lanes_c%0d: strobe=%h size=%0d data=%h want ff/3/1122334455667788",
                                  i, dbus.dreq_strobe, dbus.dreq_size, dbus.dreq_data);
            end
            n_vec++;
            if (stallM !== 1'b1 || dataM.valid !== 1'b0) begin
                n_err++; $display("FAIL sd_wait_c%0d: stallM=%b valid=%b want 1/0", i, stallM, dataM.valid);
            end
            next_cycle;
        end
        dbus.dresp_ok = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b1 || stallM !== 1'b0 || dataM.ctl.regwrite !== 1'b0) begin
            n_err++; $display("FAIL sd_done: dreq_valid=%b stallM=%b regwrite=%b want 1/0/0",
                              dbus.dreq_valid, stallM, dataM.ctl.regwrite);
        end
        n_vec++;
        if (dataM.valid !== 1'b1) begin
            n_err++; $display("FAIL sd_sb_valid: valid=%b want 1", dataM.valid);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sd_sb_empty: queue size 0 want 1");
        end else begin
            e = exp_q.pop_front();
            if (dataM.pc !== e.pc || (e.wd_chk && dataM.wd !== e.wd)) begin
                n_err++; $display("FAIL sd_sb: pc=%h wd=%h want pc=%h wd=%h", dataM.pc, dataM.wd, e.pc, e.wd);
            end else begin
                $display("txn store pc=%h", dataM.pc);
            end
        end
        next_cycle;
        dbus.dresp_ok = 1'b0;
        set_bubble();
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0 || stallM !== 1'b0) begin
            n_err++; $display("FAIL sd_after: dreq_valid=%b stallM=%b want 0/0", dbus.dreq_valid, stallM);
        end
        next_cycle;
    endtask

    task automatic test_load_extend;
        sb_t     e;
        mem_op_t ops[2]  = '{MEM_LB, MEM_LBU};
        u64      wants[2] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080};
        dbus.dresp_ok   = 1'b1;
        dbus.dresp_data = 64'h0000_0000_8000_0000;
        for (int i = 0; i < 2; i++) begin
            set_op(64'h200 + 64'(4 * i), ops[i], 64'h8000_0003, 64'h0);
            exp_q.push_back('{pc: 64'h200 + 64'(4 * i), wd: wants[i], wd_chk: 1'b1});
            @(negedge clk);
            n_vec++;
            if (dbus.dreq_valid !== 1'b1 || dbus.dreq_strobe !== 8'h00 ||
                dbus.dreq_size !== MSIZE1 || stallM !== 1'b0) begin
                n_err++; $display("FAIL lb_req_%0d: valid=%b strobe=%h size=%0d stallM=%b want 1/00/0/0",
                                  i, dbus.dreq_valid, dbus.dreq_strobe, dbus.dreq_size, stallM);
            end
            n_vec++;
            if (dataM.valid !== 1'b1) begin
                n_err++; $display("FAIL lb_sb_valid_%0d: valid=%b want 1", i, dataM.valid);
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL lb_sb_empty_%0d: queue size 0 want 1", i);
            end else begin
                e = exp_q.pop_front();
                if (dataM.pc !== e.pc || (e.wd_chk && dataM.wd !== e.wd)) begin
                    n_err++; $display("FAIL lb_sb_%0d: pc=%h wd=%h want pc=%h wd=%h",
                                      i, dataM.pc, dataM.wd, e.pc, e.wd);
                end else begin
                    $display("txn load pc=%h wd=%h", dataM.pc, dataM.wd);
                end
            end
            next_cycle;
        end
        dbus.dresp_ok = 1'b0;
        set_bubble();
    endtask

    task automatic test_store_half;
        sb_t e;
        set_op(64'h300, MEM_SH, 64'h8000_0006, 64'h0000_0000_0000_BEEF);
        exp_q.push_back('{pc: 64'h300, wd: 64'h0, wd_chk: 1'b0});
        dbus.dresp_ok = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_strobe !== 8'hC0 || dbus.dreq_size !== MSIZE2) begin
            n_err++; $display("FAIL sh_strobe: strobe=%h size=%0d want c0/1", dbus.dreq_strobe, dbus.dreq_size);
        end
        n_vec++;
        if (dbus.dreq_data !== 64'hBEEF_0000_0000_0000) begin
            n_err++; $display("FAIL sh_data: data=%h want beef000000000000", dbus.dreq_data);
        end
        n_vec++;
        if (dataM.valid !== 1'b1) begin
            n_err++; $display("FAIL sh_sb_valid: valid=%b want 1", dataM.valid);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sh_sb_empty: queue size 0 want 1");
        end else begin
            e = exp_q.pop_front();
            if (dataM.pc !== e.pc || (e.wd_chk && dataM.wd !== e.wd)) begin
                n_err++; $display("FAIL sh_sb: pc=%h want pc=%h", dataM.pc, e.pc);
            end else begin
                $display("txn store pc=%h", dataM.pc);
            end
        end
        next_cycle;
        dbus.dresp_ok = 1'b0;
        set_bubble();
    endtask

    task automatic test_hold;
        sb_t e;
        set_op(64'h400, MEM_LW, 64'h8000_0004, 64'h0);
        exp_q.push_back('{pc: 64'h400, wd: 64'hFFFF_FFFF_8765_4321, wd_chk: 1'b1});
        dbus.dresp_ok   = 1'b1;
        dbus.dresp_data = 64'h8765_4321_0000_0000;
        stallW          = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b1 || stallM !== 1'b1 || dataM.valid !== 1'b0) begin
            n_err++; $display("FAIL lw_issue: dreq_valid=%b stallM=%b valid=%b want 1/1/0",
                              dbus.dreq_valid, stallM, dataM.valid);
        end
        next_cycle;
        dbus.dresp_ok   = 1'b0;
        dbus.dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0) begin
            n_err++; $display("FAIL lw_hold_noreissue: dreq_valid=%b want 0", dbus.dreq_valid);
        end
        n_vec++;
        if (stallM !== 1'b1 || dataM.valid !== 1'b0) begin
            n_err++; $display("FAIL lw_hold_stall: stallM=%b valid=%b want 1/0", stallM, dataM.valid);
        end
        n_vec++;
        if (dataM.wd !== 64'hFFFF_FFFF_8765_4321) begin
            n_err++; $display("FAIL lw_hold_wd: wd=%h want ffffffff87654321", dataM.wd);
        end
        next_cycle;
        stallW = 1'b0;
        @(negedge clk);
        n_vec++;
        if (stallM !== 1'b0 || dbus.dreq_valid !== 1'b0 || dataM.valid !== 1'b1) begin
            n_err++; $display("FAIL lw_release: stallM=%b dreq_valid=%b valid=%b want 0/0/1",
                              stallM, dbus.dreq_valid, dataM.valid);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL lw_sb_empty: queue size 0 want 1");
        end else begin
            e = exp_q.pop_front();
            if (dataM.pc !== e.pc || (e.wd_chk && dataM.wd !== e.wd)) begin
                n_err++; $display("FAIL lw_sb: pc=%h wd=%h want pc=%h wd=%h", dataM.pc, dataM.wd, e.pc, e.wd);
            end else begin
                $display("txn load pc=%h wd=%h", dataM.pc, dataM.wd);
            end
        end
        next_cycle;
        set_bubble();
    endtask

    task automatic test_non_mem;
        sb_t e;
        for (int i = 0; i < 2; i++) begin
            set_op(64'h500 + 64'(4 * i), MEM_NONE, 64'h1234 + 64'(i), 64'h0);
            if (i == 1) begin
                // Downstream stall: stage mirrors stallW and presents nothing.
                stallW = 1'b1;
                @(negedge clk);
                n_vec++;
                if (stallM !== 1'b1 || dataM.valid !== 1'b0 || dbus.dreq_valid !== 1'b0) begin
                    n_err++; $display("FAIL add_stalled: stallM=%b valid=%b dreq_valid=%b want 1/0/0",
                                      stallM, dataM.valid, dbus.dreq_valid);
                end
                next_cycle;
                stallW = 1'b0;
            end
            exp_q.push_back('{pc: 64'h500 + 64'(4 * i), wd: 64'h1234 + 64'(i), wd_chk: 1'b1});
            @(negedge clk);
            n_vec++;
            if (dbus.dreq_valid !== 1'b0 || stallM !== 1'b0) begin
                n_err++; $display("FAIL add_%0d: dreq_valid=%b stallM=%b want 0/0", i, dbus.dreq_valid, stallM);
            end
            n_vec++;
            if (dataM.valid !== 1'b1) begin
                n_err++; $display("FAIL add_sb_valid_%0d: valid=%b want 1", i, dataM.valid);
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL add_sb_empty_%0d: queue size 0 want 1", i);
            end else begin
                e = exp_q.pop_front();
                if (dataM.pc !== e.pc || (e.wd_chk && dataM.wd !== e.wd)) begin
                    n_err++; $display("FAIL add_sb_%0d: pc=%h wd=%h want pc=%h wd=%h",
                                      i, dataM.pc, dataM.wd, e.pc, e.wd);
                end else begin
                    $display("txn alu pc=%h wd=%h", dataM.pc, dataM.wd);
                end
            end
            next_cycle;
        end
        // A nop bubble carrying stale memread must not touch the bus.
        set_op(64'h508, MEM_LD, 64'h8000_0000, 64'h0);
        dataE.ctl.nop_signal = 1'b1;
        dbus.dresp_ok        = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0 || dataM.valid !== 1'b0 || stallM !== 1'b0) begin
            n_err++; $display("FAIL nop_bubble: dreq_valid=%b valid=%b stallM=%b want 0/0/0",
                              dbus.dreq_valid, dataM.valid, stallM);
        end
        next_cycle;
        dbus.dresp_ok = 1'b0;
        set_bubble();
    endtask

    task automatic test_reset_wait;
        set_op(64'h600, MEM_LD, 64'h8000_0010, 64'h0);
        dbus.dresp_ok = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b1 || stallM !== 1'b1) begin
            n_err++; $display("FAIL rw_issue: dreq_valid=%b stallM=%b want 1/1", dbus.dreq_valid, stallM);
        end
        next_cycle;
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0 || stallM !== 1'b0) begin
            n_err++; $display("FAIL rw_reset: dreq_valid=%b stallM=%b want 0/0", dbus.dreq_valid, stallM);
        end
        next_cycle;
        reset = 1'b0;
        set_bubble();
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0 || stallM !== 1'b0 || dataM.valid !== 1'b0) begin
            n_err++; $display("FAIL rw_idle: dreq_valid=%b stallM=%b valid=%b want 0/0/0",
                              dbus.dreq_valid, stallM, dataM.valid);
        end
        next_cycle;
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign;
        sb_t e;
        set_op(64'h700, MEM_LW, 64'h8000_0002, 64'h0);
        exp_q.push_back('{pc: 64'h700, wd: 64'h0, wd_chk: 1'b0});
        dbus.dresp_ok = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dbus.dreq_valid !== 1'b0 || stallM !== 1'b0) begin
            n_err++; $display("FAIL mis_noreq: dreq_valid=%b stallM=%b want 0/0", dbus.dreq_valid, stallM);
        end
        n_vec++;
        if (dataM.misalign !== 1'b1 || dataM.ctl.regwrite !== 1'b0) begin
            n_err++; $display("FAIL mis_flag: misalign=%b regwrite=%b want 1/0",
                              dataM.misalign, dataM.ctl.regwrite);
        end
        n_vec++;
        if (exp_q.size() == 0 || dataM.valid !== 1'b1) begin
            n_err++; $display("FAIL mis_sb_valid: valid=%b queued=%0d want 1/1", dataM.valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (dataM.pc !== e.pc) begin
                n_err++; $display("FAIL mis_sb: pc=%h want %h", dataM.pc, e.pc);
            end else begin
                $display("txn misalign pc=%h", dataM.pc);
            end
        end
        next_cycle;
        dbus.dresp_ok = 1'b0;
        set_bubble();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_wait();
        test_load_extend();
        test_store_half();
        test_hold();
        test_non_mem();
        test_reset_wait();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: %0d entries never completed, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
